// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared definitions for the instruction-fetch sequencer.
//   fetch_state_t : sequencer states (RUN / WAIT / FLUSH)
//   INST_BYTES    : PC increment per fetched word
//   ALIGN_BITS    : low target bits forced to zero on redirect
//   has_credit()  : buffer-credit test used before issuing a fetch
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    localparam int INST_BYTES = 4;
    localparam int ALIGN_BITS = 2;

    // Occupancy after this cycle must leave room for the fetch about to be
    // issued. 'inflight' counts the word being acked this cycle.
    function automatic logic has_credit(input logic [1:0] count,
                                        input logic       inflight,
                                        input logic       pop,
                                        input int         depth);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return int'(occ) < depth;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO of returned instructions with their fetch address.
//   clk, reset (sync, active-low)
//   push, push_pc, push_inst : write one entry
//   pop                      : drop head entry
//   flush                    : discard all entries (wins over push/pop)
//   count                    : number of valid entries
//   head_valid, head_pc, head_inst : oldest entry
module fetch_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_pc,
    input  logic [WIDTH-1:0] push_inst,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_pc,
    output logic [WIDTH-1:0] head_inst
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage has no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_inst  = inst_mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch sequencer sitting on the consumer side of
// the external PC register.
//   clk, reset          : clock, synchronous active-low reset
//   pc_q / pc_d / pc_en : PC register read-back, next value, load enable
//   imem_req/addr/ack/rdata : word fetch handshake to instruction memory
//   redirect_valid/target   : taken branch/jump, flushes stale fetches
//   inst_valid/inst/inst_pc/inst_ready : buffered instruction to decode
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               DEPTH        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] pc_d,
    output logic             pc_en,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready
);

    fetch_state_t     state, state_nxt;
    logic             req_nxt;
    logic [WIDTH-1:0] addr_nxt;
    logic             push, pop, flush;
    logic [1:0]       count;
    logic             head_valid;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] target;

    assign pc_inc = pc_q + WIDTH'(INST_BYTES);
    assign target = {redirect_target[WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

    assign inst_valid = reset & head_valid;
    assign pop        = inst_valid & inst_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = imem_req;
        addr_nxt  = imem_addr;
        pc_en     = 1'b0;
        pc_d      = pc_q;
        push      = 1'b0;
        flush     = 1'b0;
        if (!reset) begin
            pc_en = 1'b1;
            pc_d  = RESET_VECTOR;
        end else begin
            case (state)
                ST_RUN: begin
                    if (redirect_valid) begin
                        flush = 1'b1;
                        pc_en = 1'b1;
                        pc_d  = target;
                    end else if (has_credit(count, 1'b0, pop, DEPTH)) begin
                        req_nxt   = 1'b1;
                        addr_nxt  = pc_q;
                        pc_en     = 1'b1;
                        pc_d      = pc_inc;
                        state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack && redirect_valid) begin
                        // returned word belongs to the abandoned path
                        flush     = 1'b1;
                        req_nxt   = 1'b0;
                        pc_en     = 1'b1;
                        pc_d      = target;
                        state_nxt = ST_RUN;
                    end else if (imem_ack) begin
                        push = 1'b1;
                        if (has_credit(count, 1'b1, pop, DEPTH)) begin
                            addr_nxt = pc_q;
                            pc_en    = 1'b1;
                            pc_d     = pc_inc;
                        end else begin
                            req_nxt   = 1'b0;
                            state_nxt = ST_RUN;
                        end
                    end else if (redirect_valid) begin
                        // request stays outstanding; its data is dropped in FLUSH
                        flush     = 1'b1;
                        pc_en     = 1'b1;
                        pc_d      = target;
                        state_nxt = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (redirect_valid) begin
                        flush = 1'b1;
                        pc_en = 1'b1;
                        pc_d  = target;
                    end
                    if (imem_ack) begin
                        req_nxt   = 1'b0;
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    fetch_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_pc    (imem_addr),
        .push_inst  (imem_rdata),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head_valid (head_valid),
        .head_pc    (inst_pc),
        .head_inst  (inst)
    );

endmodule
